// File: rtl/image_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : image_pkg                                              |
// | Description : Shared frame-geometry defaults and FSM state encoding  |
// |               for the image bit spitter.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package image_pkg;

    // 160x120 one-bit pixels packed sixteen to a ROM word
    localparam int DEFAULT_WORD_WIDTH = 16;
    localparam int DEFAULT_NUM_WORDS  = 1200;
    localparam int DEFAULT_ADDR_WIDTH = 11;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } spitterState_t;

endpackage : image_pkg
`default_nettype wire

// File: rtl/piso_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : piso_shifter                                           |
// | Description : Parallel-load, shift-left register; the MSB is the     |
// |               serial output.                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module piso_shifter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] parallelIn,
    output logic             serialOut
);

    logic [WIDTH-1:0] r_shiftReg;

    // Load takes priority over shift; the vacated LSB fills with zero
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_shiftReg <= '0;
        end else if (load) begin
            r_shiftReg <= parallelIn;
        end else if (shift) begin
            r_shiftReg <= {r_shiftReg[WIDTH-2:0], 1'b0};
        end
    end

    assign serialOut = r_shiftReg[WIDTH-1];

endmodule : piso_shifter
`default_nettype wire

// File: rtl/image_bit_spitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : image_bit_spitter                                      |
// | Description : Streams one frame from a synchronous image ROM as a    |
// |               serial bit stream with valid/ready handshake, word MSB |
// |               first.                                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module image_bit_spitter
    import image_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] romAddress,
    input  logic [WORD_WIDTH-1:0] romData,
    output logic                  bitOut,
    output logic                  bitValid,
    input  logic                  bitReady,
    output logic                  busy,
    output logic                  done
);

    localparam int BIT_INDEX_WIDTH = $clog2(WORD_WIDTH);
    localparam logic [BIT_INDEX_WIDTH-1:0] C_LAST_BIT  = BIT_INDEX_WIDTH'(WORD_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0]      C_LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

    spitterState_t              r_state;
    spitterState_t              w_nextState;
    logic [ADDR_WIDTH-1:0]      r_wordIndex;
    logic [ADDR_WIDTH-1:0]      w_wordIndexNext;
    logic [BIT_INDEX_WIDTH-1:0] r_bitIndex;
    logic [BIT_INDEX_WIDTH-1:0] w_bitIndexNext;
    logic [ADDR_WIDTH-1:0]      r_romAddress;
    logic                       w_load;
    logic                       w_shift;

    // State register
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state, counter-next and shifter control decode
    always_comb begin
        w_nextState     = r_state;
        w_wordIndexNext = r_wordIndex;
        w_bitIndexNext  = r_bitIndex;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState     = FETCH;
                    w_wordIndexNext = '0;
                end
            end
            FETCH: begin
                w_nextState = LOAD;
            end
            LOAD: begin
                w_load         = 1'b1;
                w_bitIndexNext = '0;
                w_nextState    = SHIFT;
            end
            SHIFT: begin
                // Nothing moves unless the downstream accepts the bit
                if (bitReady) begin
                    w_shift = 1'b1;
                    if (r_bitIndex == C_LAST_BIT) begin
                        // Counter parks on the last bit; LOAD clears it
                        if (r_wordIndex == C_LAST_WORD) begin
                            w_nextState = DONE;
                        end else begin
                            w_wordIndexNext = r_wordIndex + ADDR_WIDTH'(1);
                            w_nextState     = FETCH;
                        end
                    end else begin
                        w_bitIndexNext = r_bitIndex + BIT_INDEX_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Counters and ROM address; the address is launched on entry to FETCH
    // so the synchronous ROM returns the word during LOAD
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_wordIndex  <= '0;
            r_bitIndex   <= '0;
            r_romAddress <= '0;
        end else begin
            r_wordIndex <= w_wordIndexNext;
            r_bitIndex  <= w_bitIndexNext;
            if (w_nextState == FETCH) begin
                r_romAddress <= w_wordIndexNext;
            end
        end
    end

    piso_shifter #(
        .WIDTH (WORD_WIDTH)
    ) u_shifter (
        .clock      (clock),
        .resetN     (resetN),
        .load       (w_load),
        .shift      (w_shift),
        .parallelIn (romData),
        .serialOut  (bitOut)
    );

    assign romAddress = r_romAddress;
    assign bitValid   = (r_state == SHIFT);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

endmodule : image_bit_spitter
`default_nettype wire

// File: tb/tb_image_bit_spitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_image_bit_spitter                                   |
// | Description : Self-checking bench for image_bit_spitter with a       |
// |               1-cycle-latency ROM model and a bit-queue reference.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_image_bit_spitter;

    localparam int WW     = 16;
    localparam int NW     = 2;
    localparam int AW     = 11;
    localparam int BUDGET = 2000;

    logic          clock = 1'b0;
    logic          resetN;
    logic          start;
    logic [AW-1:0] romAddress;
    logic [WW-1:0] romData;
    logic          bitOut;
    logic          bitValid;
    logic          bitReady;
    logic          busy;
    logic          done;

    logic [WW-1:0] rom [NW];

    int checks = 0;
    int errors = 0;

    image_bit_spitter #(
        .WORD_WIDTH (WW),
        .NUM_WORDS  (NW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .start      (start),
        .romAddress (romAddress),
        .romData    (romData),
        .bitOut     (bitOut),
        .bitValid   (bitValid),
        .bitReady   (bitReady),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data one cycle after the address
    always @(posedge clock) begin
        if (int'(romAddress) < NW) romData <= rom[int'(romAddress)];
        else                       romData <= '0;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // readyMode: 0 always ready, 1 toggling, 2 random.
    // restartAt: transfer count at which start is re-pulsed (-1 none).
    // resetAt:   transfer count at which reset is pulsed (-1 none).
    task automatic runFrame(input int readyMode, input int restartAt, input int resetAt);
        logic          q[$];
        logic [WW-1:0] assembled = '0;
        logic          lastStall = 1'b0;
        logic          stallBit  = 1'b0;
        logic          r;
        logic          pulsed    = 1'b0;
        int            transfers = 0;
        int            stalls    = 0;
        int            gap       = 0;
        int            lastXfer  = -1;
        int            firstValid = -1;
        int            k;
        bit            finished  = 0;
        bit            aborted   = 0;
        int            total     = NW * WW;

        for (int w = 0; w < NW; w++)
            for (int b = WW - 1; b >= 0; b--)
                q.push_back(rom[w][b]);

        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 1;
        while (k < BUDGET && !finished && !aborted) begin
            r = (readyMode == 0) ? 1'b1 : (readyMode == 1) ? 1'(k % 2) : 1'($urandom % 2);
            if (restartAt >= 0 && !pulsed && bitValid && transfers == restartAt) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (resetAt >= 0 && bitValid && transfers == resetAt) begin
                resetN = 1'b0;
                @(negedge clock);
                resetN = 1'b1;
                checkValue("rstBitValid", bitValid, 0);
                checkValue("rstBitOut", bitOut, 0);
                checkValue("rstBusy", busy, 0);
                checkValue("rstDone", done, 0);
                checkValue("rstRomAddr", romAddress, 0);
                for (int i = 0; i < 6; i++) begin
                    @(negedge clock);
                    checkValue("abortNoDone", done, 0);
                    checkValue("abortIdle", busy, 0);
                end
                aborted = 1;
            end else begin
                checkValue("busyInFrame", busy, 1);
                bitReady = r;
                if (!bitValid) begin
                    if (lastStall) checkValue("stallValid", bitValid, 1);
                    lastStall = 1'b0;
                    if (done) begin
                        checkValue("doneAfterLast", transfers, total);
                        checkValue("doneLatency", k, lastXfer + 1);
                        checkValue("frameCycles", k, NW * (WW + 2) + 1 + stalls);
                        finished = 1;
                    end else begin
                        gap++;
                        if (gap == 1) checkValue("romAddress", romAddress, transfers / WW);
                        if (gap > 2) checkValue("gapTooLong", gap, 2);
                    end
                end else begin
                    checkValue("doneLowInShift", done, 0);
                    if (gap != 0) checkValue("gapLen", gap, 2);
                    gap = 0;
                    if (firstValid < 0) begin
                        firstValid = k;
                        checkValue("firstValidLatency", k, 3);
                    end
                    if (lastStall) checkValue("stallHold", bitOut, stallBit);
                    if (r) begin
                        checkValue("bit", bitOut, (q.size() > 0) ? q.pop_front() : 1'bx);
                        assembled = {assembled[WW-2:0], bitOut};
                        transfers++;
                        lastXfer  = k;
                        lastStall = 1'b0;
                        if (transfers % WW == 0)
                            checkValue("word", assembled, rom[transfers / WW - 1]);
                    end else begin
                        stalls++;
                        lastStall = 1'b1;
                        stallBit  = bitOut;
                    end
                end
                @(negedge clock);
                k++;
            end
        end
        start = 1'b0;
        if (!finished && !aborted) checkValue("frameTimeout", 0, 1);
        if (finished) begin
            checkValue("doneSingle", done, 0);
            checkValue("busyAfterDone", busy, 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                checkValue("noQueuedStart", busy, 0);
            end
        end
    endtask

    initial begin
        resetN   = 1'b0;
        start    = 1'b0;
        bitReady = 1'b0;
        rom[0]   = 16'hA5F0;
        rom[1]   = 16'h0001;
        repeat (3) @(negedge clock);
        checkValue("resetBitValid", bitValid, 0);
        checkValue("resetBitOut", bitOut, 0);
        checkValue("resetBusy", busy, 0);
        checkValue("resetDone", done, 0);
        checkValue("resetRomAddr", romAddress, 0);
        resetN = 1'b1;
        @(negedge clock);
        checkValue("idleBusy", busy, 0);

        runFrame(0, -1, -1);        // steady stream
        runFrame(1, -1, -1);        // toggling ready
        runFrame(0, 5, -1);         // start re-pulsed mid word 0
        runFrame(0, -1, WW + 5);    // reset at bit 5 of word 1
        runFrame(0, -1, -1);        // restart from word 0
        for (int n = 0; n < 4; n++) begin
            rom[0] = 16'($urandom);
            rom[1] = 16'($urandom);
            runFrame(2, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_image_bit_spitter
`default_nettype wire
